// File: rtl/sort9_stream.sv
// Streaming 9-element sorter: an 11-stage odd-even transposition network with a valid/ready handshake.
// Optional macro SORT9_STREAM_STATS_EN adds a 16-bit out_count of completed output handshakes.
module sort9_stream #(
   parameter int W       = 8,
   parameter int SIGNED  = 0,
   parameter int DESCEND = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9*W-1:0]   in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [9*W-1:0]   out_sorted,
   output logic [W-1:0]     out_median,
   output logic [W-1:0]     out_min,
`ifdef SORT9_STREAM_STATS_EN
   output logic [15:0]      out_count,
`endif
   output logic [W-1:0]     out_max
);

   localparam int STAGES = 11;
   localparam int N      = 9;

   logic             en;
   logic [W-1:0]     stage_q [STAGES][N];
   logic             stage_v [STAGES];
   logic [W-1:0]     net_in  [STAGES][N];
   logic [W-1:0]     net_out [STAGES][N];
   logic [W-1:0]     med_q;
   logic [W-1:0]     min_q;
   logic [W-1:0]     max_q;

   // True when a must be placed after b in the output order.
   function automatic logic out_of_order(input logic [W-1:0] a, input logic [W-1:0] b);
      logic gt_ab;
      logic gt_ba;
      if (SIGNED != 0) begin
         gt_ab = $signed(a) > $signed(b);
         gt_ba = $signed(b) > $signed(a);
      end else begin
         gt_ab = a > b;
         gt_ba = b > a;
      end
      return (DESCEND != 0) ? gt_ba : gt_ab;
   endfunction

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = stage_v[STAGES-1];

   // Even stages compare pairs (0,1),(2,3).. and odd stages (1,2),(3,4)..;
   // nine rounds fully sort nine elements, the last two rounds are no-ops on sorted data.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      for (genvar k = 0; k < N; k++) begin : g_elem
         if (s == 0) begin : g_src_in
            assign net_in[s][k] = in_data[k*W +: W];
         end else begin : g_src_q
            assign net_in[s][k] = stage_q[s-1][k];
         end

         if (k >= (s % 2) && ((k - (s % 2)) % 2) == 0 && k < N-1) begin : g_lo
            assign net_out[s][k] = out_of_order(net_in[s][k], net_in[s][k+1])
                                 ? net_in[s][k+1] : net_in[s][k];
         end else if (k >= (s % 2) + 1 && ((k - (s % 2) - 1) % 2) == 0) begin : g_hi
            assign net_out[s][k] = out_of_order(net_in[s][k-1], net_in[s][k])
                                 ? net_in[s][k-1] : net_in[s][k];
         end else begin : g_pass
            assign net_out[s][k] = net_in[s][k];
         end
      end
   end

   // Whole pipeline advances together on en; min/median/max are taken from the
   // final stage's network outputs so they land in the same cycle as out_sorted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            stage_v[s] <= 1'b0;
            for (int k = 0; k < N; k++) begin
               stage_q[s][k] <= '0;
            end
         end
         med_q <= '0;
         min_q <= '0;
         max_q <= '0;
      end else if (en) begin
         stage_v[0] <= in_valid;
         for (int s = 1; s < STAGES; s++) begin
            stage_v[s] <= stage_v[s-1];
         end
         for (int s = 0; s < STAGES; s++) begin
            for (int k = 0; k < N; k++) begin
               stage_q[s][k] <= net_out[s][k];
            end
         end
         med_q <= net_out[STAGES-1][4];
         min_q <= (DESCEND != 0) ? net_out[STAGES-1][N-1] : net_out[STAGES-1][0];
         max_q <= (DESCEND != 0) ? net_out[STAGES-1][0]   : net_out[STAGES-1][N-1];
      end
   end

   always_comb begin
      out_sorted = '0;
      for (int k = 0; k < N; k++) begin
         out_sorted[k*W +: W] = stage_q[STAGES-1][k];
      end
   end

   assign out_median = med_q;
   assign out_min    = min_q;
   assign out_max    = max_q;

`ifdef SORT9_STREAM_STATS_EN
   logic [15:0] count_q;

   // Counts completed output handshakes, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (out_valid && out_ready) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign out_count = count_q;
`endif

endmodule

// File: tb/tb_sort9_stream.sv
// Directed bench for sort9_stream: an unsigned ascending instance plus a signed descending instance.
module tb_sort9_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [71:0] out_sorted;
   logic [7:0]  out_median;
   logic [7:0]  out_min;
   logic [7:0]  out_max;

   logic        in_valid_s;
   logic        in_ready_s;
   logic [71:0] in_data_s;
   logic        out_valid_s;
   logic [71:0] out_sorted_s;
   logic [7:0]  out_median_s;
   logic [7:0]  out_min_s;
   logic [7:0]  out_max_s;

   int passCount;
   int totalCount;

   sort9_stream #(.W(8), .SIGNED(0), .DESCEND(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sorted (out_sorted),
      .out_median (out_median),
      .out_min    (out_min),
      .out_max    (out_max)
   );

   sort9_stream #(.W(8), .SIGNED(1), .DESCEND(1)) dut_s (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_s),
      .in_ready   (in_ready_s),
      .in_data    (in_data_s),
      .out_valid  (out_valid_s),
      .out_ready  (1'b1),
      .out_sorted (out_sorted_s),
      .out_median (out_median_s),
      .out_min    (out_min_s),
      .out_max    (out_max_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [71:0] pack9(input logic [7:0] e0, input logic [7:0] e1,
                                         input logic [7:0] e2, input logic [7:0] e3,
                                         input logic [7:0] e4, input logic [7:0] e5,
                                         input logic [7:0] e6, input logic [7:0] e7,
                                         input logic [7:0] e8);
      return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [71:0] d,
                                input logic vs, input logic [71:0] ds);
      in_valid   = v;
      in_data    = d;
      in_valid_s = vs;
      in_data_s  = ds;
   endtask

   task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   logic [71:0] vecA, vecB, vecC, vecD, vecF, vecS;
   logic [71:0] expA, expB, expC, expD, expF, expS;
   logic        sawValid;

   initial begin
      passCount  = 0;
      totalCount = 0;
      vecA = pack9(8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4, 8'd5);
      expA = pack9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
      vecB = pack9(8'd0, 8'd255, 8'd128, 8'd127, 8'd1, 8'd254, 8'd2, 8'd3, 8'd100);
      expB = pack9(8'd0, 8'd1, 8'd2, 8'd3, 8'd100, 8'd127, 8'd128, 8'd254, 8'd255);
      vecC = pack9(8'd7, 8'd7, 8'd3, 8'd3, 8'd9, 8'd9, 8'd1, 8'd1, 8'd7);
      expC = pack9(8'd1, 8'd1, 8'd3, 8'd3, 8'd7, 8'd7, 8'd7, 8'd9, 8'd9);
      vecD = pack9(8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10);
      expD = pack9(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90);
      vecF = pack9(8'd50, 8'd40, 8'd60, 8'd10, 8'd90, 8'd20, 8'd80, 8'd30, 8'd70);
      expF = expD;
      vecS = pack9(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h81, 8'h02, 8'hFE);
      expS = pack9(8'h7F, 8'h02, 8'h01, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'h81, 8'h80);

      // Reset state.
      rst_n     = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, '0);
      tick();
      tick();
      checkOutput("reset_out_valid", {71'd0, out_valid}, 72'd0);
      checkOutput("reset_out_sorted", out_sorted, 72'd0);
      checkOutput("reset_median", {64'd0, out_median}, 72'd0);
      checkOutput("reset_min", {64'd0, out_min}, 72'd0);
      checkOutput("reset_max", {64'd0, out_max}, 72'd0);
      checkOutput("reset_in_ready", {71'd0, in_ready}, 72'd1);
      rst_n = 1'b1;
      tick();

      // Single set through both instances, latency 11.
      applyStimulus(1'b1, vecA, 1'b1, vecS);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0);
      repeat (9) tick();
      checkOutput("latA_not_early", {71'd0, out_valid}, 72'd0);
      tick();
      checkOutput("latA_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("A_sorted", out_sorted, expA);
      checkOutput("A_median", {64'd0, out_median}, 72'd5);
      checkOutput("A_min", {64'd0, out_min}, 72'd1);
      checkOutput("A_max", {64'd0, out_max}, 72'd9);
      checkOutput("S_valid", {71'd0, out_valid_s}, 72'd1);
      checkOutput("S_sorted", out_sorted_s, expS);
      checkOutput("S_median", {64'd0, out_median_s}, 72'h00);
      checkOutput("S_min", {64'd0, out_min_s}, 72'h80);
      checkOutput("S_max", {64'd0, out_max_s}, 72'h7F);
      tick();
      checkOutput("A_one_cycle", {71'd0, out_valid}, 72'd0);

      // Back-to-back sets with an output stall.
      applyStimulus(1'b1, vecB, 1'b0, '0);
      tick();
      applyStimulus(1'b1, vecC, 1'b0, '0);
      tick();
      applyStimulus(1'b1, vecD, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0);
      repeat (8) tick();
      checkOutput("B_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("B_sorted", out_sorted, expB);
      checkOutput("B_median", {64'd0, out_median}, 72'd100);
      out_ready = 1'b0;
      #1;
      checkOutput("stall_in_ready", {71'd0, in_ready}, 72'd0);
      repeat (3) tick();
      checkOutput("stall_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("stall_sorted", out_sorted, expB);
      checkOutput("stall_median", {64'd0, out_median}, 72'd100);
      checkOutput("stall_in_ready_hold", {71'd0, in_ready}, 72'd0);
      out_ready = 1'b1;
      tick();
      checkOutput("C_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("C_sorted", out_sorted, expC);
      checkOutput("C_median", {64'd0, out_median}, 72'd7);
      tick();
      checkOutput("D_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("D_sorted", out_sorted, expD);
      checkOutput("D_min_max", {56'd0, out_min, out_max}, {56'd0, 8'd10, 8'd90});
      tick();
      checkOutput("after_D_idle", {71'd0, out_valid}, 72'd0);

      // Reset with sets in flight.
      applyStimulus(1'b1, vecD, 1'b0, '0);
      tick();
      applyStimulus(1'b1, vecC, 1'b0, '0);
      tick();
      applyStimulus(1'b1, vecB, 1'b0, '0);
      tick();
      applyStimulus(1'b1, vecA, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", {71'd0, out_valid}, 72'd0);
      checkOutput("midrst_in_ready", {71'd0, in_ready}, 72'd1);
      tick();
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         sawValid = sawValid | out_valid;
      end
      checkOutput("midrst_no_leftover", {71'd0, sawValid}, 72'd0);
      applyStimulus(1'b1, vecF, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0);
      repeat (9) tick();
      checkOutput("latF_not_early", {71'd0, out_valid}, 72'd0);
      tick();
      checkOutput("latF_valid", {71'd0, out_valid}, 72'd1);
      checkOutput("F_sorted", out_sorted, expF);
      checkOutput("F_median", {64'd0, out_median}, 72'd50);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/sort9_stream.md
SORT9_STREAM -- requirements
Module: sort9_stream

Interface
REQ-001 Parameter W, default 8, data element width in bits (W >= 2) SHALL be supported.
REQ-002 Parameter SIGNED, default 0, SHALL select comparison: 0 unsigned, 1 two's-complement.
REQ-003 Parameter DESCEND, default 0, SHALL select order: 0 ascending (slot 0 = smallest), 1 descending.
REQ-004 clk  input  1  SHALL be the sole clock, rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL flag a valid 9-element set on in_data.
REQ-007 in_ready  output  1  SHALL flag that the block accepts in_data this cycle.
REQ-008 in_data  input  9*W  SHALL carry element k in bits [k*W +: W], k = 0..8.
REQ-009 out_valid  output  1  SHALL flag valid result on all out_* data ports.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 out_sorted  output  9*W  SHALL carry sorted slot k in bits [k*W +: W].
REQ-012 out_median  output  W  SHALL equal sorted slot 4.
REQ-013 out_min / out_max  output  W each  SHALL equal the smallest / largest element under the active SIGNED rule, independent of DESCEND.

Function
REQ-014 The block SHALL fully sort the 9 elements with a compare-exchange network of exactly 11 register stages; the network topology is free provided the result is a correct full sort.
REQ-015 Pipeline enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-016 An input set SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 All stage data and valid registers SHALL advance only on edges where en = 1; with en = 0 every stage SHALL hold.
REQ-018 A set accepted on enabled edge E1 SHALL appear on the outputs with out_valid = 1 after enabled edge E11 (latency 11 cycles at out_ready = 1).
REQ-019 Throughput SHALL be one set per cycle while out_ready = 1; no bubbles SHALL be inserted.
REQ-020 Bubbles (in_valid = 0 on an enabled edge) SHALL propagate as valid = 0 and SHALL NOT stall later sets.
REQ-021 With out_valid = 1 and out_ready = 0, all out_* data SHALL remain stable until the handshake.
REQ-022 Equal elements SHALL produce equal values in adjacent slots; no tie-break ordering is observable.
REQ-023 SIGNED = 1: 8'h80 SHALL sort below 8'h7F; SIGNED = 0: above.
REQ-024 out_median, out_min, out_max SHALL be registered copies aligned with out_sorted, not extra combinational depth after the last stage.

Reset
REQ-025 rst_n low SHALL asynchronously clear all stage valid bits and data registers to 0.
REQ-026 During and after reset: out_valid = 0, out_sorted = 0, out_median = 0, out_min = 0, out_max = 0, in_ready = 1.
REQ-027 Reset mid-operation SHALL discard every in-flight set; no partial result SHALL appear after release.
REQ-028 The first set accepted after release SHALL obey REQ-018 exactly.

Configuration
REQ-029 Macro SORT9_STREAM_STATS_EN, when defined, SHALL add output port out_count (16 bits) incrementing by 1 on each edge with out_valid && out_ready, wrapping 16'hFFFF -> 16'h0000, reset to 0 by rst_n.
REQ-030 Without SORT9_STREAM_STATS_EN, out_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 W=8, unsigned, ascending, in_data elements {9,3,7,1,8,2,6,4,5}, out_ready=1 -> after 11 cycles out_sorted = {1..9}, out_median=5, out_min=1, out_max=9, out_valid high exactly 1 cycle.
REQ-032 Back-to-back 20 random sets, out_ready=1 -> 20 consecutive out_valid cycles starting cycle 11, each matching a reference sort, in order.
REQ-033 out_ready=0 for cycles 14..19 during a 20-set stream -> in_ready low same cycles, outputs stable, no set lost or duplicated, order preserved.
REQ-034 SIGNED=1, DESCEND=1, elements {8'h80,8'h7F,0,8'hFF,1,1,8'h81,2,8'hFE} -> out_sorted slot0..8 = {7F,2,1,1,0,FF,FE,81,80}, out_median=00, out_min=80, out_max=7F.
REQ-035 rst_n pulsed low at cycle 5 with 4 sets in flight -> out_valid stays 0 until a new set, accepted after release, emerges 11 cycles later.
REQ-036 With SORT9_STREAM_STATS_EN, 65537 handshakes -> out_count = 1.
